// File: rtl/pwm_capture_if.sv
// Measurement port bundle of pwm_capture: the raw PWM pin in, and the published
// measurement and line-health flags out.
interface pwm_capture_if #(
    parameter int CNT_W = 16
);
    logic             pwm_in;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic [3:0]       duty_tenths;
    logic             meas_valid;
    logic             overrun;
    logic             stuck_hi;
    logic             stuck_lo;

    modport master (
        input  pwm_in,
        output high_cnt, period_cnt, duty_tenths, meas_valid, overrun, stuck_hi, stuck_lo
    );

    modport slave (
        output pwm_in,
        input  high_cnt, period_cnt, duty_tenths, meas_valid, overrun, stuck_hi, stuck_lo
    );
endinterface

// File: rtl/pwm_capture.sv
// PWM receiver: measures high time and period of an asynchronous PWM input,
// publishes duty in 10 % steps via an 11-step serial divider, and flags stuck lines.
//
// state  | meaning
// IDLE   | line high or synchronizer warming up; waiting for a low level
// ARM    | line low; next rise starts a measured period
// HIGH   | counting high phase (hcnt) and period (pcnt)
// LOW    | counting period only; next rise captures and restarts
module pwm_capture #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    pwm_capture_if.master cap
);
    localparam int               N_W     = CNT_W + 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_HIGH, S_LOW} state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] warm;
    logic                   pwm_s, pwm_d, rise, fall;
    state_t                 state;
    logic [CNT_W-1:0]       hcnt, pcnt, age;
    logic                   age_sat, pcnt_sat, capture;

    logic                   div_busy, div_free;
    logic [3:0]             div_it, div_q;
    logic [N_W-1:0]         div_n, div_d;
    logic [CNT_W-1:0]       div_h, div_p;

    assign pwm_s    = sync_q[SYNC_STAGES-1];
    assign rise     = pwm_s & ~pwm_d;
    assign fall     = ~pwm_s & pwm_d;
    assign age_sat  = (age == CNT_MAX - CNT_W'(1)) && !rise && !fall;
    assign pcnt_sat = (pcnt == CNT_MAX);
    assign capture  = (state == S_LOW) && rise && !pcnt_sat;
    assign div_free = !div_busy || (div_it == 4'd11);

    // warm fills once the synchronizer holds real samples, so a line that is
    // already high at reset release is not mistaken for a low level in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            pwm_d  <= 1'b0;
            warm   <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], cap.pwm_in};
            pwm_d  <= pwm_s;
            warm   <= {warm[SYNC_STAGES-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            hcnt         <= '0;
            pcnt         <= '0;
            age          <= '0;
            cap.stuck_hi <= 1'b0;
            cap.stuck_lo <= 1'b0;
        end else begin
            if (rise || fall) begin
                age <= '0;
            end else if (age != CNT_MAX) begin
                age <= age + CNT_W'(1);
            end

            if (fall) cap.stuck_hi <= 1'b0;
            if (rise) cap.stuck_lo <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (warm[SYNC_STAGES-1] && !pwm_s) state <= S_ARM;
                end
                S_ARM: begin
                    if (rise) begin
                        hcnt  <= CNT_W'(1);
                        pcnt  <= CNT_W'(1);
                        state <= S_HIGH;
                    end
                end
                S_HIGH: begin
                    if (pcnt_sat) begin
                        state <= pwm_s ? S_IDLE : S_ARM;
                    end else begin
                        pcnt <= pcnt + CNT_W'(1);
                        if (fall) state <= S_LOW;
                        else      hcnt  <= hcnt + CNT_W'(1);
                    end
                end
                S_LOW: begin
                    if (pcnt_sat) begin
                        state <= pwm_s ? S_IDLE : S_ARM;
                    end else if (rise) begin
                        hcnt  <= CNT_W'(1);
                        pcnt  <= CNT_W'(1);
                        state <= S_HIGH;
                    end else begin
                        pcnt <= pcnt + CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (age_sat) begin
                if (pwm_s) begin
                    cap.stuck_hi <= 1'b1;
                    state        <= S_IDLE;
                end else begin
                    cap.stuck_lo <= 1'b1;
                    state        <= S_ARM;
                end
            end
        end
    end

    // N = 10*H + P/2 biases the truncating divide into round-half-up
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_busy        <= 1'b0;
            div_it          <= '0;
            div_q           <= '0;
            div_n           <= '0;
            div_d           <= '0;
            div_h           <= '0;
            div_p           <= '0;
            cap.high_cnt    <= '0;
            cap.period_cnt  <= '0;
            cap.duty_tenths <= '0;
            cap.meas_valid  <= 1'b0;
            cap.overrun     <= 1'b0;
        end else begin
            cap.meas_valid <= div_busy && (div_it == 4'd11);
            cap.overrun    <= capture && !div_free;

            if (div_busy && (div_it == 4'd11)) begin
                cap.high_cnt    <= div_h;
                cap.period_cnt  <= div_p;
                cap.duty_tenths <= div_q;
            end

            if (capture && div_free) begin
                div_n    <= N_W'({hcnt, 3'b000}) + N_W'({hcnt, 1'b0}) + N_W'(pcnt >> 1);
                div_d    <= N_W'(pcnt);
                div_q    <= '0;
                div_it   <= '0;
                div_busy <= 1'b1;
                div_h    <= hcnt;
                div_p    <= pcnt;
            end else if (div_busy) begin
                if (div_it == 4'd11) begin
                    div_busy <= 1'b0;
                end else begin
                    if (div_n >= div_d) begin
                        div_n <= div_n - div_d;
                        div_q <= div_q + 4'd1;
                    end
                    div_it <= div_it + 4'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_pwm_capture.sv
// Randomized self-checking bench for pwm_capture; expectations come from edge
// times of the driven waveform and the rounding rule round(10*H/P), half up.
module tb_pwm_capture;
    localparam int CNT_W = 16;
    localparam int SYNC  = 2;
    localparam int DIV_LAT = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    pwm_capture_if #(.CNT_W(CNT_W)) cap ();

    pwm_capture #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .cap  (cap)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    logic sh_prev = 1'b0;

    int rise_q[$], fall_q[$];
    int mv_cyc[$], mv_h[$], mv_p[$], mv_d[$], ov_cyc[$], sh_set[$], sh_clr[$];
    int exp_cyc[$], exp_h[$], exp_p[$], exp_d[$], exp_ov[$];

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (cap.meas_valid === 1'b1) begin
                mv_cyc.push_back(cyc);
                mv_h.push_back(int'(cap.high_cnt));
                mv_p.push_back(int'(cap.period_cnt));
                mv_d.push_back(int'(cap.duty_tenths));
            end
            if (cap.overrun === 1'b1) ov_cyc.push_back(cyc);
            if (cap.stuck_hi !== sh_prev) begin
                if (cap.stuck_hi === 1'b1) sh_set.push_back(cyc);
                else                       sh_clr.push_back(cyc);
                sh_prev = cap.stuck_hi;
            end
        end
    end

    // Drive a level starting at the next falling clock edge for n clock cycles.
    task automatic hold(input logic v, input int n);
        @(negedge clk);
        if (v && !cap.pwm_in) rise_q.push_back(cyc + 1);
        if (!v && cap.pwm_in) fall_q.push_back(cyc + 1);
        cap.pwm_in = v;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic clear_obs();
        rise_q.delete(); fall_q.delete();
        mv_cyc.delete(); mv_h.delete(); mv_p.delete(); mv_d.delete();
        ov_cyc.delete(); sh_set.delete(); sh_clr.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        cap.pwm_in = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_obs();
    endtask

    // Reference: every rise after the first closes a period; the divider takes
    // a capture only if the previous accepted one is at least DIV_LAT old.
    function automatic void predict();
        int busy_until, h, p, c;
        busy_until = 0;
        exp_cyc.delete(); exp_h.delete(); exp_p.delete(); exp_d.delete(); exp_ov.delete();
        for (int i = 0; i + 1 < rise_q.size(); i++) begin
            h = fall_q[i] - rise_q[i];
            p = rise_q[i+1] - rise_q[i];
            c = rise_q[i+1] + SYNC;
            if (c >= busy_until) begin
                exp_cyc.push_back(c + DIV_LAT);
                exp_h.push_back(h);
                exp_p.push_back(p);
                exp_d.push_back((20 * h + p) / (2 * p));
                busy_until = c + DIV_LAT;
            end else begin
                exp_ov.push_back(c);
            end
        end
    endfunction

    task automatic test_reset();
        cap.pwm_in = 1'($urandom_range(0, 1));
        repeat (3) @(negedge clk);
        total++; if (cap.high_cnt !== '0)    begin bad++; $display("FAIL rst_high_cnt got=%0h want=0", cap.high_cnt); end
        total++; if (cap.period_cnt !== '0)  begin bad++; $display("FAIL rst_period_cnt got=%0h want=0", cap.period_cnt); end
        total++; if (cap.duty_tenths !== '0) begin bad++; $display("FAIL rst_duty got=%0h want=0", cap.duty_tenths); end
        total++; if (cap.meas_valid !== 1'b0) begin bad++; $display("FAIL rst_meas_valid got=%b want=0", cap.meas_valid); end
        total++; if (cap.overrun !== 1'b0)    begin bad++; $display("FAIL rst_overrun got=%b want=0", cap.overrun); end
        total++; if (cap.stuck_hi !== 1'b0)   begin bad++; $display("FAIL rst_stuck_hi got=%b want=0", cap.stuck_hi); end
        total++; if (cap.stuck_lo !== 1'b0)   begin bad++; $display("FAIL rst_stuck_lo got=%b want=0", cap.stuck_lo); end
        cap.pwm_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        do_reset();
        hold(0, 10);
        repeat (5) begin hold(1, 30); hold(0, 70); end
        hold(1, 30); hold(0, 30);
        predict();
        total++;
        if (mv_cyc.size() !== exp_cyc.size()) begin bad++; $display("FAIL basic_count got=%0d want=%0d", mv_cyc.size(), exp_cyc.size()); end
        for (int i = 0; i < mv_cyc.size() && i < exp_cyc.size(); i++) begin
            total++;
            if (mv_cyc[i] !== exp_cyc[i] || mv_h[i] !== exp_h[i] || mv_p[i] !== exp_p[i] || mv_d[i] !== exp_d[i]) begin
                bad++;
                $display("FAIL basic_meas[%0d] got cyc=%0d h=%0d p=%0d d=%0d want cyc=%0d h=%0d p=%0d d=%0d",
                         i, mv_cyc[i], mv_h[i], mv_p[i], mv_d[i], exp_cyc[i], exp_h[i], exp_p[i], exp_d[i]);
            end
        end
        total++;
        if (ov_cyc.size() !== 0) begin bad++; $display("FAIL basic_overrun got=%0d pulses want=0", ov_cyc.size()); end
    endtask

    task automatic test_rounding();
        int th[5] = '{25, 35, 1, 99, 5};
        int tl[5] = '{75, 65, 99, 1, 5};
        int h, l;
        for (int k = 0; k < 11; k++) begin
            if (k < 5) begin h = th[k]; l = tl[k]; end
            else begin h = $urandom_range(1, 60); l = $urandom_range(1, 60); end
            do_reset();
            hold(0, 10);
            repeat (2) begin hold(1, h); hold(0, l); end
            hold(1, h); hold(0, 20);
            predict();
            total++;
            if (mv_cyc.size() !== exp_cyc.size() || ov_cyc.size() !== exp_ov.size()) begin
                bad++;
                $display("FAIL round_count[%0d] H=%0d L=%0d got mv=%0d ov=%0d want mv=%0d ov=%0d",
                         k, h, l, mv_cyc.size(), ov_cyc.size(), exp_cyc.size(), exp_ov.size());
            end
            for (int i = 0; i < mv_cyc.size() && i < exp_cyc.size(); i++) begin
                total++;
                if (mv_cyc[i] !== exp_cyc[i] || mv_h[i] !== exp_h[i] || mv_p[i] !== exp_p[i] || mv_d[i] !== exp_d[i]) begin
                    bad++;
                    $display("FAIL round_meas[%0d.%0d] H=%0d L=%0d got cyc=%0d h=%0d p=%0d d=%0d want cyc=%0d h=%0d p=%0d d=%0d",
                             k, i, h, l, mv_cyc[i], mv_h[i], mv_p[i], mv_d[i], exp_cyc[i], exp_h[i], exp_p[i], exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_overrun();
        do_reset();
        hold(0, 10);
        repeat (6) begin hold(1, 3); hold(0, 3); end
        hold(1, 3); hold(0, 20);
        predict();
        total++;
        if (mv_cyc.size() !== exp_cyc.size()) begin bad++; $display("FAIL ovr_mv_count got=%0d want=%0d", mv_cyc.size(), exp_cyc.size()); end
        for (int i = 0; i < mv_cyc.size() && i < exp_cyc.size(); i++) begin
            total++;
            if (mv_cyc[i] !== exp_cyc[i] || mv_h[i] !== 3 || mv_p[i] !== 6 || mv_d[i] !== 5) begin
                bad++;
                $display("FAIL ovr_meas[%0d] got cyc=%0d h=%0d p=%0d d=%0d want cyc=%0d h=3 p=6 d=5",
                         i, mv_cyc[i], mv_h[i], mv_p[i], mv_d[i], exp_cyc[i]);
            end
        end
        total++;
        if (ov_cyc.size() !== exp_ov.size()) begin bad++; $display("FAIL ovr_count got=%0d want=%0d", ov_cyc.size(), exp_ov.size()); end
        for (int i = 0; i < ov_cyc.size() && i < exp_ov.size(); i++) begin
            total++;
            if (ov_cyc[i] !== exp_ov[i]) begin bad++; $display("FAIL ovr_cyc[%0d] got=%0d want=%0d", i, ov_cyc[i], exp_ov[i]); end
        end
    endtask

    task automatic test_stuck();
        int r_last, f;
        do_reset();
        hold(0, 10);
        hold(1, 30); hold(0, 70);
        hold(1, 70000);
        predict();
        r_last = rise_q[rise_q.size()-1];
        total++;
        if (mv_cyc.size() !== 1 || exp_cyc.size() !== 1 || mv_cyc[0] !== exp_cyc[0] || mv_h[0] !== exp_h[0] || mv_p[0] !== exp_p[0]) begin
            bad++;
            $display("FAIL stuck_pre_meas got n=%0d want n=%0d h=%0d p=%0d", mv_cyc.size(), exp_cyc.size(), exp_h[0], exp_p[0]);
        end
        total++;
        if (sh_set.size() !== 1 || sh_set[0] !== r_last + SYNC + 65535) begin
            bad++;
            $display("FAIL stuck_hi_set got n=%0d cyc=%0d want cyc=%0d", sh_set.size(),
                     (sh_set.size() > 0) ? sh_set[0] : -1, r_last + SYNC + 65535);
        end
        total++;
        if (cap.high_cnt !== 16'd30 || cap.period_cnt !== 16'd100 || cap.stuck_lo !== 1'b0) begin
            bad++;
            $display("FAIL stuck_hold got h=%0d p=%0d lo=%b want h=30 p=100 lo=0", cap.high_cnt, cap.period_cnt, cap.stuck_lo);
        end
        hold(0, 70);
        f = fall_q[fall_q.size()-1];
        total++;
        if (sh_clr.size() !== 1 || sh_clr[0] !== f + SYNC) begin
            bad++;
            $display("FAIL stuck_hi_clr got n=%0d cyc=%0d want cyc=%0d", sh_clr.size(),
                     (sh_clr.size() > 0) ? sh_clr[0] : -1, f + SYNC);
        end
        clear_obs();
        repeat (2) begin hold(1, 30); hold(0, 70); end
        hold(1, 30); hold(0, 30);
        predict();
        total++;
        if (mv_cyc.size() !== exp_cyc.size()) begin bad++; $display("FAIL stuck_post_count got=%0d want=%0d", mv_cyc.size(), exp_cyc.size()); end
        for (int i = 0; i < mv_cyc.size() && i < exp_cyc.size(); i++) begin
            total++;
            if (mv_cyc[i] !== exp_cyc[i] || mv_h[i] !== exp_h[i] || mv_p[i] !== exp_p[i] || mv_d[i] !== exp_d[i]) begin
                bad++;
                $display("FAIL stuck_post_meas[%0d] got cyc=%0d h=%0d p=%0d d=%0d want cyc=%0d h=%0d p=%0d d=%0d",
                         i, mv_cyc[i], mv_h[i], mv_p[i], mv_d[i], exp_cyc[i], exp_h[i], exp_p[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        hold(0, 10);
        hold(1, 30); hold(0, 70);
        hold(1, 20);
        total++;
        if (cap.high_cnt !== 16'd30) begin bad++; $display("FAIL mid_pre got h=%0d want=30", cap.high_cnt); end
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({cap.high_cnt, cap.period_cnt, cap.duty_tenths, cap.meas_valid, cap.overrun, cap.stuck_hi, cap.stuck_lo} !== '0) begin
            bad++;
            $display("FAIL mid_rst_outputs got h=%0h p=%0h d=%0h mv=%b ov=%b sh=%b sl=%b want all 0",
                     cap.high_cnt, cap.period_cnt, cap.duty_tenths, cap.meas_valid, cap.overrun, cap.stuck_hi, cap.stuck_lo);
        end
        rst_n = 1'b1;
        clear_obs();
        hold(1, 50); hold(0, 70);
        total++;
        if (mv_cyc.size() !== 0 || ov_cyc.size() !== 0) begin
            bad++;
            $display("FAIL mid_spurious got mv=%0d ov=%0d want 0 0", mv_cyc.size(), ov_cyc.size());
        end
        clear_obs();
        repeat (2) begin hold(1, 40); hold(0, 60); end
        hold(1, 40); hold(0, 30);
        predict();
        total++;
        if (mv_cyc.size() !== exp_cyc.size()) begin bad++; $display("FAIL mid_count got=%0d want=%0d", mv_cyc.size(), exp_cyc.size()); end
        for (int i = 0; i < mv_cyc.size() && i < exp_cyc.size(); i++) begin
            total++;
            if (mv_cyc[i] !== exp_cyc[i] || mv_h[i] !== exp_h[i] || mv_p[i] !== exp_p[i] || mv_d[i] !== exp_d[i]) begin
                bad++;
                $display("FAIL mid_meas[%0d] got cyc=%0d h=%0d p=%0d d=%0d want cyc=%0d h=%0d p=%0d d=%0d",
                         i, mv_cyc[i], mv_h[i], mv_p[i], mv_d[i], exp_cyc[i], exp_h[i], exp_p[i], exp_d[i]);
            end
        end
    endtask

    // Edges land at random sub-cycle offsets (never on a rising clock edge).
    function automatic int jit();
        int j;
        j = $urandom_range(1, 18);
        if (j >= 10) j++;
        return j;
    endfunction

    task automatic test_async();
        longint base, t;
        do_reset();
        hold(0, 10);
        @(posedge clk);
        base = $time + 10;
        for (int k = 0; k < 6; k++) begin
            t = base + longint'(k) * 20000 + jit();
            #(t - $time);
            cap.pwm_in = 1'b1;
            t = base + longint'(k) * 20000 + 6000 + jit();
            #(t - $time);
            cap.pwm_in = 1'b0;
        end
        repeat (40) @(negedge clk);
        total++;
        if (mv_cyc.size() !== 5 || ov_cyc.size() !== 0) begin
            bad++;
            $display("FAIL async_count got mv=%0d ov=%0d want mv=5 ov=0", mv_cyc.size(), ov_cyc.size());
        end
        for (int i = 0; i < mv_cyc.size(); i++) begin
            total++;
            if (mv_h[i] < 299 || mv_h[i] > 301 || mv_p[i] < 999 || mv_p[i] > 1001 || mv_d[i] !== 3) begin
                bad++;
                $display("FAIL async_meas[%0d] got h=%0d p=%0d d=%0d want h=300+-1 p=1000+-1 d=3",
                         i, mv_h[i], mv_p[i], mv_d[i]);
            end
        end
    endtask

    initial begin
        cap.pwm_in = 1'b0;
        rst_n = 1'b0;
        test_reset();
        test_basic();
        test_rounding();
        test_overrun();
        test_reset_mid();
        test_async();
        test_stuck();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM waveform (period, high time, duty cycle in 10 % steps), the receive-side counterpart to the team's push-button PWM generator. It sits on a dedicated input pin in the same `tt_um_*` top. It reports a fresh measurement once per captured period and flags a line stuck high or stuck low. Typical use: loop-back checking of the generator's 10 %-step output, or decoding an external PWM command.

## Interface
- `CNT_W`, default 16: width of the cycle counters and of the `high_cnt`/`period_cnt` outputs.
- `SYNC_STAGES`, default 2 (minimum 2): number of synchronizer flops on `pwm_in`.

- `clk`  in  1  system clock (100 MHz in the top).
- `rst_n`  in  1  reset; one clock domain, reset is asynchronous and active-low.
- `pwm_in`  in  1  PWM input; asynchronous to `clk`.
- `high_cnt`  out  CNT_W  high-phase length of the last published period, in clk cycles.
- `period_cnt`  out  CNT_W  last published period, rising edge to rising edge, in clk cycles.
- `duty_tenths`  out  4  rounded duty, 0..10 (units of 10 %).
- `meas_valid`  out  1  one-cycle pulse when the three outputs above update.
- `overrun`  out  1  one-cycle pulse when a completed period is dropped because the divider is busy.
- `stuck_hi`  out  1  level; no edge for 2^CNT_W−1 cycles while the input is high.
- `stuck_lo`  out  1  level; no edge for 2^CNT_W−1 cycles while the input is low.

## Operation
- Synchronizer: `SYNC_STAGES` flops give `pwm_s`, followed by one more flop giving `pwm_d`. All of these reset to 0.
  - rise = `pwm_s & ~pwm_d`
  - fall = `~pwm_s & pwm_d`
- FSM states:
  - IDLE: wait until `pwm_s`=0, then go to ARM. This stops a line that is already high at reset release from producing a truncated high phase.
  - ARM: on rise, clear `hcnt` and `pcnt` to 1 and go to HIGH.
  - HIGH: `hcnt` and `pcnt` increment each cycle. On fall, go to LOW and freeze `hcnt`.
  - LOW: `pcnt` increments. On rise, perform a capture of (`hcnt`, `pcnt`), reload both counters to 1, and go to HIGH.
- For a clean waveform with H high cycles and L low cycles, the capture is `hcnt`=H and `pcnt`=H+L.
- Edge-age counter: resets on any rise or fall and saturates at 2^CNT_W−1.
  - On reaching saturation with `pwm_s`=1: set `stuck_hi` and go to IDLE.
  - On reaching saturation with `pwm_s`=0: set `stuck_lo` and go to ARM.
  - `stuck_hi` clears on the next fall; `stuck_lo` clears on the next rise.
- `pcnt` saturation in HIGH or LOW: discard the period with no pulse of any kind. Go to IDLE if `pwm_s`=1, otherwise ARM.
- Divider:
  - At capture (divider idle), load numerator N = 10·hcnt + (pcnt>>1) and denominator D = pcnt. Width of N and D is CNT_W+4.
  - Run exactly 11 iterations, one per cycle: if N≥D then N←N−D and q←q+1.
  - q = floor((10H + floor(P/2)) / P), so exact .5 cases round half up. q is 0..10 by construction.
- A capture that arrives while the divider is busy is dropped and `overrun` pulses. The FSM still reloads and continues counting.
- Reset mid-operation: everything returns immediately to the reset state. Any measurement in progress is lost.

## Timing
- Reset values:
  - All outputs are 0, and `duty_tenths`=0.
  - FSM is in IDLE, and the divider is idle.
- Edge recognition: a `pwm_in` transition sampled at edge k is acted on at edge k+SYNC_STAGES, called C for a capture.
- Divider load happens at C. Iterations happen at C+1..C+11.
- At C+12, `high_cnt`, `period_cnt` and `duty_tenths` update, and `meas_valid`=1 for that one cycle.
- The divider accepts a new capture on the same edge C+12. Captures at C+1..C+11 are dropped.
- `overrun` pulses on the drop edge.
- `stuck_*` sets on the edge where the age counter reaches 2^CNT_W−1. It clears on the edge that processes the clearing transition.
- The outputs hold their last published values until the next `meas_valid`. Stuck events do not zero them.

## Test plan
- H=30, L=70 repeated, driven on clk → first `meas_valid` 12 cycles after the second processed rise, with `high_cnt`=30, `period_cnt`=100, `duty_tenths`=3. Thereafter one pulse every 100 cycles and no `overrun`.
- Rounding cases:
  - H=25, L=75 → 3
  - H=35, L=65 → 4
  - H=1, L=99 → 0
  - H=99, L=1 → 10
  - H=5, L=5 → 5
- H=3, L=3 → captures at C, C+6, C+12, …
  - Loads happen at C and C+12; `overrun` at C+6 and C+18.
  - `meas_valid` every 12 cycles with `period_cnt`=6, `high_cnt`=3, `duty_tenths`=5.
- `pwm_in` held high for 70000 cycles (CNT_W=16):
  - `stuck_hi` rises exactly 65535 cycles after the last processed edge.
  - The following fall clears it.
  - The next `meas_valid` comes only after two further rises.
- `rst_n` asserted mid-HIGH with `pwm_in` held high at release:
  - All outputs read 0 during reset.
  - No capture until `pwm_in` goes low, then two rises.
  - The first result is correct.
- Async check: `pwm_in` with random phase relative to clk, H=300, L=700 → `high_cnt` within 300±1, `period_cnt` within 1000±1, `duty_tenths`=3 throughout.
